// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Reusable pipeline segment register carrying a control bundle and
//             a data bundle between CPU stages. It has a valid/ready handshake,
//             a one-entry skid buffer for back-pressure, a synchronous flush
//             that inserts a bubble, and a saturating bubble counter.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1       rising-edge clock
//    rst        in   1       asynchronous active-low reset
//    in_valid   in   1       upstream entry valid
//    in_ready   out  1       block can accept an entry (register output)
//    in_ctrl    in   CTRL_W  upstream control bundle
//    in_data    in   DATA_W  upstream data bundle
//    flush      in   1       synchronous kill of all held entries
//    out_valid  out  1       outputs hold a valid entry
//    out_ready  in   1       downstream consumes the entry this cycle
//    out_ctrl   out  CTRL_W  held control bundle, zero when out_valid=0
//    out_data   out  DATA_W  held data bundle, zero when out_valid=0
//    bubble_cnt out  CNT_W   saturating count of cycles with out_valid=0
// ============================================================================
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 68,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // Main entry drives the outputs directly; the skid entry is always younger.
  logic              r_main_valid;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_accept;
  logic w_consume;

  // in_ready depends only on registered skid state, so there is no
  // combinational path from out_ready back to the upstream stage.
  assign w_accept  = in_valid && !r_skid_valid;
  assign w_consume = r_main_valid && out_ready;

  // Invalid entries are always zeroed so outputs need no gating and ctrl bits
  // read zero on every bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
    end else if (!r_main_valid || w_consume) begin
      if (r_skid_valid) begin
        // Drain the older skid entry first; in_ready was low, so no accept.
        r_main_valid <= 1'b1;
        r_main_ctrl  <= r_skid_ctrl;
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
        r_skid_ctrl  <= '0;
        r_skid_data  <= '0;
      end else if (w_accept) begin
        r_main_valid <= 1'b1;
        r_main_ctrl  <= in_ctrl;
        r_main_data  <= in_data;
      end else begin
        r_main_valid <= 1'b0;
        r_main_ctrl  <= '0;
        r_main_data  <= '0;
      end
    end else if (w_accept) begin
      // Main is stalled: absorb one extra entry into the skid buffer.
      r_skid_valid <= 1'b1;
      r_skid_ctrl  <= in_ctrl;
      r_skid_data  <= in_data;
    end
  end

  // Counts cycles whose pre-edge out_valid is low, flushed cycles included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubble_cnt <= '0;
    end else if (!r_main_valid && (r_bubble_cnt != c_cnt_max)) begin
      r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
    end
  end

  assign in_ready   = !r_skid_valid;
  assign out_valid  = r_main_valid;
  assign out_ctrl   = r_main_ctrl;
  assign out_data   = r_main_data;
  assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire
